// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and baud divisor helper,
// used by uart_tx and the future uart_rx.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq,
                                                     input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses
// o_bit_tick on the last count; i_clear restarts the period.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_bit_tick
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last     = (r_cnt == LAST);
   assign o_bit_tick = i_en && w_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter fed by the TX FIFO's valid/busy handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned BAUD_RATE = 115200,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       busy,
   output logic       tx
);

   localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam logic [2:0]  LAST_STOP    = 3'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_chk_cpb
      $error("uart_tx: CLKS_PER_BIT must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   uart_state_e r_state, w_state_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic [2:0]  r_bit_cnt, w_bit_nxt;
   logic        r_tx, w_tx_nxt;
   logic        r_busy, w_busy_nxt;
   logic        w_accept;
   logic        w_bit_tick;
`ifdef UART_TX_PARITY_EN
   logic        r_parity, w_parity_nxt;
`endif

   assign w_accept = (r_state == ST_IDLE) && valid_in && !r_busy;
   assign busy     = r_busy;
   assign tx       = r_tx;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_accept),
      .i_en      (r_state != ST_IDLE),
      .o_bit_tick(w_bit_tick)
   );

   // tx holds the value for the state being entered, so every pin change
   // is decided one cycle early and then registered.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_bit_nxt   = r_bit_cnt;
      w_tx_nxt    = r_tx;
      w_busy_nxt  = r_busy;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt = r_parity;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_START;
               w_shift_nxt = data_in;
               w_bit_nxt   = '0;
               w_tx_nxt    = 1'b0;
               w_busy_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
               w_parity_nxt = ^data_in;
`endif
            end
         end
         ST_START: begin
            if (w_bit_tick) begin
               w_state_nxt = ST_DATA;
               w_tx_nxt    = r_shift[0];
            end
         end
         ST_DATA: begin
            if (w_bit_tick) begin
               if (r_bit_cnt == 3'd7) begin
                  w_bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = ST_PARITY;
                  w_tx_nxt    = r_parity;
`else
                  w_state_nxt = ST_STOP;
                  w_tx_nxt    = 1'b1;
`endif
               end else begin
                  w_shift_nxt = r_shift >> 1;
                  w_bit_nxt   = r_bit_cnt + 3'd1;
                  w_tx_nxt    = r_shift[1];
               end
            end
         end
         ST_PARITY: begin
`ifdef UART_TX_PARITY_EN
            if (w_bit_tick) begin
               w_state_nxt = ST_STOP;
               w_tx_nxt    = 1'b1;
            end
`else
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
`endif
         end
         ST_STOP: begin
            // bit counter is reused to count stop bits
            if (w_bit_tick) begin
               if (r_bit_cnt == LAST_STOP) begin
                  w_state_nxt = ST_IDLE;
                  w_bit_nxt   = '0;
                  w_tx_nxt    = 1'b1;
                  w_busy_nxt  = 1'b0;
               end else begin
                  w_bit_nxt = r_bit_cnt + 3'd1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_tx      <= w_tx_nxt;
         r_busy    <= w_busy_nxt;
`ifdef UART_TX_PARITY_EN
         r_parity  <= w_parity_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: CLKS_PER_BIT=4, one instance with 1 stop bit, one with 2.
// Expected frames come from a byte/parity scoreboard decoded by a tx monitor.
module tb_uart_tx;

   localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned PAR = 1;
`else
   localparam int unsigned PAR = 0;
`endif
   localparam int unsigned FRAME_A = 10 * CPB + PAR * CPB;
   localparam int unsigned FRAME_B = 11 * CPB + PAR * CPB;
   localparam int unsigned LOW_B   = 9 * CPB + PAR * CPB;

   typedef struct {
      logic [7:0] data;
      logic       par;
   } exp_t;

   typedef struct {
      logic [7:0]  data;
      logic        par;
      int unsigned gap;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] data_a = '0, data_b = '0;
   logic       valid_a = 1'b0, valid_b = 1'b0;
   logic       busy_a, tx_a, busy_b, tx_b;

   int          n_vec = 0;
   int          n_err = 0;
   bit          mon_en = 1'b0;
   exp_t        sb_q[$];
   int unsigned gap_q[$];
   logic [7:0]  fifo_q[$];
   vec_t        vt[6];

   always #5 clk = ~clk;

   uart_tx #(.CLK_FREQ(400), .BAUD_RATE(100), .STOP_BITS(1)) u_dut_a (
      .clk(clk), .rst(rst), .data_in(data_a), .valid_in(valid_a), .busy(busy_a), .tx(tx_a)
   );

   uart_tx #(.CLK_FREQ(400), .BAUD_RATE(100), .STOP_BITS(2)) u_dut_b (
      .clk(clk), .rst(rst), .data_in(data_b), .valid_in(valid_b), .busy(busy_b), .tx(tx_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] d, input logic p, input int unsigned idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (PAR != 0 && idx == 9) return p;
      return 1'b1;
   endfunction

   // Decodes every frame on instance A cycle by cycle against the scoreboard.
   initial begin : mon_a
      exp_t        e;
      int unsigned len, bad, idle;
      idle = 0;
      forever begin
         @(negedge clk);
         if (rst && mon_en && busy_a === 1'b1) begin
            gap_q.push_back(idle);
            idle = 0;
            if (sb_q.size() == 0) begin
               check("unexpected_frame", sb_q.size(), 1);
               e.data = '0;
               e.par  = 1'b0;
            end else begin
               e = sb_q.pop_front();
            end
            len = 0;
            bad = 0;
            do begin
               if (tx_a !== exp_bit(e.data, e.par, len / CPB)) bad++;
               len++;
               @(negedge clk);
            end while (busy_a === 1'b1 && len < 400);
            check($sformatf("frame_bits_%02h", e.data), bad, 0);
            check($sformatf("busy_len_%02h", e.data), len, FRAME_A);
            check("idle_after_stop", tx_a, 1);
            idle = 1;
         end else if (busy_a === 1'b0 && tx_a === 1'b1) begin
            idle++;
         end
      end
   end

   task automatic send_a(input logic [7:0] d, input logic p);
      exp_t e;
      @(negedge clk);
      data_a  = d;
      valid_a = 1'b1;
      e.data  = d;
      e.par   = p;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check("accept_busy", busy_a, 1);
      check("accept_start_bit", tx_a, 0);
      valid_a = 1'b0;
   endtask

   task automatic wait_idle_a();
      int unsigned n = 0;
      while (busy_a !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy_a !== 1'b0) check("wait_idle_timeout", busy_a, 0);
      @(negedge clk);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int unsigned n, lowc, highc, busyc, glitch;
      exp_t        e;

      vt[0] = '{data: 8'h55, par: 1'b0, gap: 2};
      vt[1] = '{data: 8'h07, par: 1'b1, gap: 0};
      vt[2] = '{data: 8'h03, par: 1'b0, gap: 5};
      vt[3] = '{data: 8'h00, par: 1'b0, gap: 1};
      vt[4] = '{data: 8'hFF, par: 1'b0, gap: 0};
      vt[5] = '{data: 8'h3C, par: 1'b0, gap: 3};

      // power-on reset
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_tx_a", tx_a, 1);
         check("rst_busy_a", busy_a, 0);
         check("rst_tx_b", tx_b, 1);
         check("rst_busy_b", busy_b, 0);
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("idle_tx_a", tx_a, 1);
         check("idle_busy_a", busy_a, 0);
      end
      mon_en = 1'b1;

      foreach (vt[i]) begin
         send_a(vt[i].data, vt[i].par);
         wait_idle_a();
         repeat (vt[i].gap) @(negedge clk);
      end

      // second valid while busy must be dropped
      send_a(8'hA3, 1'b0);
      repeat (9) @(negedge clk);
      data_a  = 8'hFF;
      valid_a = 1'b1;
      @(posedge clk);
      #1;
      check("ignore_busy_held", busy_a, 1);
      valid_a = 1'b0;
      wait_idle_a();
      repeat (60) @(negedge clk);
      check("no_second_frame", busy_a, 0);

      // FIFO-style presenter: valid for one cycle whenever busy is low
      gap_q.delete();
      fifo_q = '{8'h01, 8'h80, 8'hFF};
      e = '{data: 8'h01, par: 1'b1}; sb_q.push_back(e);
      e = '{data: 8'h80, par: 1'b1}; sb_q.push_back(e);
      e = '{data: 8'hFF, par: 1'b0}; sb_q.push_back(e);
      n = 0;
      while ((fifo_q.size() > 0 || busy_a === 1'b1 || valid_a === 1'b1) && n < 600) begin
         @(negedge clk);
         n++;
         if (fifo_q.size() > 0 && busy_a === 1'b0) begin
            data_a  = fifo_q.pop_front();
            valid_a = 1'b1;
         end else begin
            valid_a = 1'b0;
         end
      end
      valid_a = 1'b0;
      wait_idle_a();
      check("fifo_frames", gap_q.size(), 3);
      check("fifo_gap_1", (gap_q.size() > 1) ? gap_q[1] : 999, 1);
      check("fifo_gap_2", (gap_q.size() > 2) ? gap_q[2] : 999, 1);

      // two stop bits on instance B
      @(negedge clk);
      data_b  = 8'h00;
      valid_b = 1'b1;
      @(posedge clk);
      #1;
      check("b_accept_busy", busy_b, 1);
      valid_b = 1'b0;
      lowc = 0; highc = 0; busyc = 0; glitch = 0; n = 0;
      @(negedge clk);
      while (busy_b === 1'b1 && n < 400) begin
         busyc++;
         if (tx_b === 1'b0 && highc == 0) lowc++;
         else if (tx_b === 1'b1) highc++;
         else glitch++;
         n++;
         @(negedge clk);
      end
      check("b_low_cycles", lowc, LOW_B);
      check("b_high_cycles", highc, 2 * CPB);
      check("b_busy_cycles", busyc, FRAME_B);
      check("b_glitch", glitch, 0);
      check("b_idle_tx", tx_b, 1);

      // asynchronous reset mid-frame
      mon_en = 1'b0;
      @(negedge clk);
      data_a  = 8'h00;
      valid_a = 1'b1;
      @(posedge clk);
      #1;
      valid_a = 1'b0;
      repeat (6) @(negedge clk);
      check("pre_rst_tx", tx_a, 0);
      check("pre_rst_busy", busy_a, 1);
      #2;
      rst = 1'b0;
      #1;
      check("rst_async_tx", tx_a, 1);
      check("rst_async_busy", busy_a, 0);
      repeat (3) begin
         @(negedge clk);
         check("rst_hold_tx", tx_a, 1);
         check("rst_hold_busy", busy_a, 0);
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_tx", tx_a, 1);
      check("post_rst_busy", busy_a, 0);

      // recovery after the aborted frame
      mon_en = 1'b1;
      send_a(8'h55, 1'b0);
      wait_idle_a();
      repeat (2) @(negedge clk);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit asynchronous serial transmitter (8N1 default) directly downstream of the UART TX FIFO.
- Consumes the FIFO's byte/valid pair and drives the FIFO's busy input.
- Serialises each byte LSB-first onto the tx pin at a fixed baud rate derived from the system clock.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, integer-truncated. Elaboration error if CLKS_PER_BIT < 2.
- STOP_BITS, 1: number of stop bits, 1 or 2. Any other value is an elaboration error.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  8  byte from the FIFO data output.
- valid_in  input  1  byte available, from the FIFO valid output.
- busy  output  1  frame in progress, to the FIFO busy input.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (rst low, asynchronous): tx=1, busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=0. A frame in progress is abandoned immediately; tx goes high in the same cycle.
- Accept rule: on a rising edge where state=IDLE and valid_in=1 and busy=0:
  - latch data_in into the shift register;
  - set busy=1 and tx=0 (start bit) on that same edge, both registered.
- valid_in is ignored while busy=1.
- Handshake compatibility: the FIFO holds valid_in high for one cycle while busy=0, so busy must rise on exactly the edge that accepts the byte. Consequences:
  - no byte is lost;
  - no byte is accepted twice.
- FSM states and transitions:
  - IDLE -> START on accept.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit counter (0..7). After bit 7 completes -> PARITY (feature enabled) or STOP.
  - PARITY: tx = parity bit for CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles -> IDLE, with busy=0 on the same edge.
- Baud counter:
  - counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary;
  - cleared on accept;
  - width $clog2(CLKS_PER_BIT).
- Frame length, with busy high for exactly this many cycles:
  - (10 + STOP_BITS - 1) * CLKS_PER_BIT;
  - add CLKS_PER_BIT when parity is enabled.
- Back-to-back operation: a new byte may be accepted on the first edge after busy falls. The FIFO needs one cycle to re-present, so the minimum idle gap between frames is one clk of tx=1 beyond the stop bit(s).
- tx is registered, so no combinational glitches appear on the pin.
- No receive path and no flow-control pins.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA;
  - parity bit = XOR of the 8 data bits, i.e. even parity;
  - frame grows by one bit time.
- Undefined:
  - PARITY state and parity logic are absent;
  - DATA goes directly to STOP.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP), 3-bit;
  - constant function computing CLKS_PER_BIT from CLK_FREQ and BAUD_RATE.
- The future uart_rx reuses the same package.
- One natural sub-module, uart_baud_gen: the baud counter with a sync clear, emitting a one-cycle bit_tick at count CLKS_PER_BIT-1.

Test Plan (CLK_FREQ=400, BAUD_RATE=100 -> CLKS_PER_BIT=4, STOP_BITS=1 unless noted):
- Reset: hold rst low 3 cycles, then release -> tx=1, busy=0 throughout. Assert rst low mid-frame -> tx=1, busy=0 in the same cycle, no further edges.
- Single byte: valid_in pulse with data_in=0x55 -> busy rises on the accept edge and stays high 40 cycles. tx bit sequence, 4 clk each: 0,1,0,1,0,1,0,1,0,1.
- Ignore while busy: second valid_in pulse with 0xFF issued 10 cycles into a 0xA3 frame -> the frame is 0xA3 only (bits 1,1,0,0,0,1,0,1 after start), and no second frame follows.
- FIFO integration: write 0x01, 0x80, 0xFF into uart_fifo_simple connected to this block:
  - three frames emitted in order;
  - each separated by exactly one idle clk of tx=1 after the stop bit.
- STOP_BITS=2: byte 0x00 -> tx low 36 cycles (start + 8 data), high 8 cycles, busy high 44 cycles.
- UART_TX_PARITY_EN defined:
  - 0x07 -> parity bit 1, frame 44 cycles;
  - 0x03 -> parity bit 0.
